cla_adder_16: RTL and testbench

- 16-bit two-level carry-lookahead adder with registered outputs.
- Computes a + b + cin and exports the sum, carry-out, and the group propagate/generate signals, so several instances can be cascaded under a higher-level lookahead unit.
- Used as the adder building block of the CPU32 datapath ALU.

---
 rtl/cla_adder_16.sv | 81 ++++++++
 tb/tb_cla_adder_16.sv | 133 +++++++++++++
 2 files changed

// File: rtl/cla_adder_16.sv
// 16-bit two-level carry-lookahead adder with registered sum, carry-out and group P/G.
// Four 4-bit lookahead blocks feed a second-level lookahead unit; no carry ripples between bits or blocks.
module cla_adder_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout,
  output logic        pg,
  output logic        gg
);

  // Carries c[0..3] of a 4-wide lookahead stage from its propagate/generate terms and carry-in.
  // This shape serves both the bit-level blocks and the block-level unit.
  function automatic logic [3:0] lookahead4(input logic [3:0] p, input logic [3:0] g,
                                            input logic ci);
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  function automatic logic generate4(input logic [3:0] p, input logic [3:0] g);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  logic [15:0] bit_p, bit_g, bit_c;
  logic [3:0]  blk_p, blk_g, blk_c;

  logic [15:0] s_d, s_q;
  logic        cout_d, cout_q;
  logic        pg_d, pg_q;
  logic        gg_d, gg_q;

  always_comb begin
    bit_p = a ^ b;
    bit_g = a & b;

    for (int k = 0; k < 4; k++) begin
      blk_p[k] = &bit_p[4*k +: 4];
      blk_g[k] = generate4(bit_p[4*k +: 4], bit_g[4*k +: 4]);
    end

    blk_c = lookahead4(blk_p, blk_g, cin);

    for (int k = 0; k < 4; k++) begin
      bit_c[4*k +: 4] = lookahead4(bit_p[4*k +: 4], bit_g[4*k +: 4], blk_c[k]);
    end

    s_d    = bit_p ^ bit_c;
    pg_d   = &blk_p;
    gg_d   = generate4(blk_p, blk_g);
    cout_d = gg_d | (pg_d & cin);
  end

  // NOTE: reset sits in the sensitivity list so outputs clear the instant rst rises, without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= 16'h0000;
      cout_q <= 1'b0;
      pg_q   <= 1'b0;
      gg_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples values from before this edge, never a sibling's new value.
      s_q    <= s_d;
      cout_q <= cout_d;
      pg_q   <= pg_d;
      gg_q   <= gg_d;
    end
  end

  assign s    = s_q;
  assign cout = cout_q;
  assign pg   = pg_q;
  assign gg   = gg_q;

endmodule

// File: tb/tb_cla_adder_16.sv
// Self-checking bench for cla_adder_16: directed corner cases plus randomized operands
// checked against an arithmetic reference model, one edge of latency.
module tb_cla_adder_16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic        cin;
  logic [15:0] s;
  logic        cout, pg, gg;

  int checks = 0;
  int errors = 0;

  cla_adder_16 dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .cin (cin),
    .s   (s),
    .cout(cout),
    .pg  (pg),
    .gg  (gg)
  );

  always #5 clk = ~clk;

  // Reference result packed as {cout, pg, gg, s}.
  function automatic logic [18:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mc);
    logic [16:0] sum, sum_nc;
    logic        m_pg;
    sum    = {1'b0, ma} + {1'b0, mb} + {16'h0000, mc};
    sum_nc = {1'b0, ma} + {1'b0, mb};
    m_pg   = ((ma ^ mb) == 16'hFFFF);
    return {sum[16], m_pg, sum_nc[16], sum[15:0]};
  endfunction

  task automatic check(input string tag, input logic [18:0] observed, input logic [18:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive operands, wait one edge, compare all outputs against the model.
  task automatic step(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                      input logic tc);
    a   = ta;
    b   = tb_;
    cin = tc;
    @(posedge clk);
    #1;
    check(tag, {cout, pg, gg, s}, model(ta, tb_, tc));
  endtask

  // Same as step, additionally pinning {cout, s} to a hand-derived constant.
  task automatic step_k(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic tc, input logic [16:0] want);
    step(tag, ta, tb_, tc);
    check({tag, "_const"}, {cout, s}, want);
  endtask

  initial begin
    rst = 1'b1;
    a   = 16'h1234;
    b   = 16'h1111;
    cin = 1'b1;

    #1;
    check("reset_async", {cout, pg, gg, s}, 19'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", {cout, pg, gg, s}, 19'h0);
    end

    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_release", {cout, pg, gg, s}, {1'b0, 1'b0, 1'b0, 16'h2346});

    step_k("prop_cin1", 16'hFFFF, 16'h0000, 1'b1, {1'b1, 16'h0000});
    check("prop_cin1_pg_gg", {pg, gg}, 2'b10);
    step_k("prop_cin0", 16'hFFFF, 16'h0000, 1'b0, {1'b0, 16'hFFFF});
    check("prop_cin0_pg_gg", {pg, gg}, 2'b10);

    step_k("gen_msb", 16'h8000, 16'h8000, 1'b0, {1'b1, 16'h0000});
    check("gen_msb_pg_gg", {pg, gg}, 2'b01);
    step_k("wrap_all", 16'hFFFF, 16'hFFFF, 1'b1, {1'b1, 16'hFFFF});
    check("wrap_all_gg", {1'b0, gg}, 2'b01);
    step_k("wrap_one", 16'hFFFF, 16'h0001, 1'b0, {1'b1, 16'h0000});

    step_k("grp_0fff", 16'h0FFF, 16'h0001, 1'b0, {1'b0, 16'h1000});
    step_k("grp_00ff", 16'h00FF, 16'h0000, 1'b1, {1'b0, 16'h0100});
    step_k("grp_000f", 16'h000F, 16'h0000, 1'b1, {1'b0, 16'h0010});

    step_k("pipe_0", 16'h0001, 16'h0002, 1'b0, {1'b0, 16'h0003});
    step_k("pipe_1", 16'h7FFF, 16'h0001, 1'b0, {1'b0, 16'h8000});
    step_k("pipe_2", 16'hABCD, 16'h5432, 1'b1, {1'b1, 16'h0000});

    // Reset pulsed between edges must clear outputs at once and drop the pending result.
    a   = 16'h1111;
    b   = 16'h2222;
    cin = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst", {cout, pg, gg, s}, 19'h0);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_hold", {cout, pg, gg, s}, 19'h0);
    @(posedge clk);
    #1;
    check("mid_rst_recover", {cout, pg, gg, s}, model(16'h1111, 16'h2222, 1'b0));

    // Random sweep with new operands every cycle; a quarter force full propagate so pg=1 is exercised.
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = (i % 4 == 0) ? ~ra : 16'($urandom);
      step("random", ra, rb, 1'(i % 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
